// File: rtl/loctag_phy_pkg.sv
// loctag_phy_pkg: shared constants, ADC FSM state type and the serial CRC-32 step
// used by the loctag_phy backscatter PHY slice.
package loctag_phy_pkg;

    localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
    localparam int unsigned ADC_FRAME_BITS = 16;
    localparam int unsigned ADC_DATA_LSB   = 4;
    localparam int unsigned ADC_DATA_MSB   = 11;
    localparam int unsigned ADC_DATA_W     = ADC_DATA_MSB - ADC_DATA_LSB + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2
    } adc_state_e;

    // One MSB-first CRC-32 shift: zero init, no reflection, no final inversion.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[31];
        return {crc[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/loctag_adc_if.sv
// loctag_adc_if: serial ADC master. Runs 16 SCLK periods per conversion with
// chip select low, samples data on each SCLK rise and publishes bits 4..11.
module loctag_adc_if
    import loctag_phy_pkg::*;
#(
    parameter int unsigned ADC_DIV = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_so,
    output logic                  o_cs,
    output logic                  o_sclk,
    output logic                  o_eoc,
    output logic [ADC_DATA_W-1:0] o_data
);

    localparam int unsigned HALF = ADC_DIV / 2;
    localparam int unsigned CW   = $clog2(ADC_DIV);
    localparam int unsigned BW   = $clog2(ADC_FRAME_BITS);
    // After a full frame, bit i of the frame sits at shift position FRAME-1-i.
    localparam int unsigned DATA_TOP = ADC_FRAME_BITS - 1 - ADC_DATA_LSB;

    adc_state_e                r_state;
    adc_state_e                w_state_nxt;
    logic [CW-1:0]             r_div_cnt;
    logic [BW-1:0]             r_bit_cnt;
    logic [ADC_FRAME_BITS-1:0] r_shift;
    logic [ADC_FRAME_BITS-1:0] w_shift_nxt;
    logic                      r_eoc;
    logic [ADC_DATA_W-1:0]     r_data;
    logic                      w_div_last;
    logic                      w_bit_last;
    logic                      w_sample;
    logic                      w_done;

    assign w_div_last = (r_div_cnt == CW'(ADC_DIV - 1));
    assign w_bit_last = (r_bit_cnt == BW'(ADC_FRAME_BITS - 1));
    assign w_sample   = (r_state == CONV) && (r_div_cnt == CW'(HALF));
    assign w_done     = (r_state == CONV) && w_div_last && w_bit_last;
    assign o_eoc      = r_eoc;
    assign o_data     = r_data;

    // Next-state decode and chip-select / serial-clock generation.
    always_comb begin
        w_state_nxt = r_state;
        o_cs        = 1'b1;
        o_sclk      = 1'b1;
        case (r_state)
            IDLE: begin
                if (i_start) w_state_nxt = CONV;
            end
            CONV: begin
                o_cs   = 1'b0;
                o_sclk = (r_div_cnt >= CW'(HALF));
                if (w_div_last && w_bit_last) w_state_nxt = QUIET;
            end
            QUIET: begin
                if (w_div_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift register input: the frame enters MSB first, one bit per SCLK rise.
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_sample) w_shift_nxt = {r_shift[ADC_FRAME_BITS-2:0], i_so};
    end

    // State register plus SCLK divider and bit counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Leaving CONV or QUIET only happens on the last divider count,
            // so a wrap on w_div_last also realigns the divider per state.
            if (r_state == IDLE || w_div_last) r_div_cnt <= '0;
            else                               r_div_cnt <= r_div_cnt + 1'b1;
            if (r_state != CONV || (w_div_last && w_bit_last)) r_bit_cnt <= '0;
            else if (w_div_last)                               r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Sample capture and result publication with the end-of-conversion pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_eoc   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_shift <= w_shift_nxt;
            r_eoc   <= w_done;
            // Taken from the next shift value so a sample on the final cycle
            // (ADC_DIV == 2) is already included.
            if (w_done) r_data <= w_shift_nxt[DATA_TOP -: ADC_DATA_W];
        end
    end

endmodule

// File: rtl/loctag_phy.sv
// loctag_phy: backscatter tag PHY slice -- serial ADC interface, DBPSK
// phase-invert modulator and serial CRC-32 generator, all independent.
// Optional build macro LOCTAG_PHY_SCRAMBLER_EN adds the x^7+x^4+1 scrambler
// ahead of the differential encoder.
module loctag_phy
    import loctag_phy_pkg::*;
#(
    parameter int unsigned ADC_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  adc_start,
    output logic                  adc_cs,
    output logic                  adc_sclk,
    input  logic                  adc_so,
    output logic                  adc_eoc,
    output logic [ADC_DATA_W-1:0] adc_data,
    input  logic                  sym_tick,
    input  logic                  mod_enable,
    input  logic                  mod_in,
    output logic                  mod_out,
    input  logic                  crc_tick,
    input  logic                  crc_enable,
    input  logic                  crc_in,
    output logic [31:0]           fcs
);

    logic        r_mod_out;
    logic [31:0] r_fcs;
    logic        w_mod_b;

    assign mod_out = r_mod_out;
    assign fcs     = r_fcs;

    loctag_adc_if #(
        .ADC_DIV (ADC_DIV)
    ) u_adc_if (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_start (adc_start),
        .i_so    (adc_so),
        .o_cs    (adc_cs),
        .o_sclk  (adc_sclk),
        .o_eoc   (adc_eoc),
        .o_data  (adc_data)
    );

`ifdef LOCTAG_PHY_SCRAMBLER_EN
    logic [6:0] r_st;

    assign w_mod_b = mod_in ^ r_st[3] ^ r_st[6];

    // Scrambler state advances once per symbol; cleared while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_st <= '0;
        else if (sym_tick) r_st <= mod_enable ? {r_st[5:0], w_mod_b} : '0;
    end
`else
    assign w_mod_b = mod_in;
`endif

    // Differential encoder: a 1 bit flips the reflect-switch phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_mod_out <= 1'b0;
        else if (sym_tick) r_mod_out <= mod_enable ? (r_mod_out ^ w_mod_b) : 1'b0;
    end

    // Serial CRC-32, one data bit per strobe; disabled strobes clear it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_fcs <= '0;
        else if (crc_tick) r_fcs <= crc_enable ? crc32_step(r_fcs, crc_in) : '0;
    end

endmodule

// File: tb/tb_loctag_phy.sv
// tb_loctag_phy: directed, table-driven bench for loctag_phy.
module tb_loctag_phy;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        adc_start = 1'b0;
    logic        adc_cs;
    logic        adc_sclk;
    logic        adc_so = 1'b0;
    logic        adc_eoc;
    logic [7:0]  adc_data;
    logic        sym_tick = 1'b0;
    logic        mod_enable = 1'b0;
    logic        mod_in = 1'b0;
    logic        mod_out;
    logic        crc_tick = 1'b0;
    logic        crc_enable = 1'b0;
    logic        crc_in = 1'b0;
    logic [31:0] fcs;

    int n_checks = 0;
    int n_fail   = 0;

    loctag_phy #(.ADC_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .adc_start  (adc_start),
        .adc_cs     (adc_cs),
        .adc_sclk   (adc_sclk),
        .adc_so     (adc_so),
        .adc_eoc    (adc_eoc),
        .adc_data   (adc_data),
        .sym_tick   (sym_tick),
        .mod_enable (mod_enable),
        .mod_in     (mod_in),
        .mod_out    (mod_out),
        .crc_tick   (crc_tick),
        .crc_enable (crc_enable),
        .crc_in     (crc_in),
        .fcs        (fcs)
    );

    always #10 clk = ~clk;

    // ADC slave model: presents the next frame bit on each SCLK fall, counts rises.
    logic [15:0] tb_frame = 16'h0;
    logic [15:0] sh = 16'h0;
    logic        prev_sclk = 1'b1;
    logic        prev_cs = 1'b1;
    int          rises = 0;

    always @(negedge clk) begin
        if (prev_cs && !adc_cs) rises = 0;
        if (adc_cs) begin
            sh        = tb_frame;
            prev_sclk = 1'b1;
        end else begin
            if (prev_sclk && !adc_sclk) begin
                adc_so = sh[15];
                sh     = {sh[14:0], 1'b0};
            end
            if (!prev_sclk && adc_sclk) rises++;
            prev_sclk = adc_sclk;
        end
        prev_cs = adc_cs;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for adc_eoc with a cycle budget; returns cycles waited.
    task automatic wait_eoc(output int n);
        n = 0;
        while (!adc_eoc && n < 200) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic        sym;
        logic        men;
        logic        min;
        logic        ctk;
        logic        cen;
        logic        cin;
        logic        exp_mod;
        logic [31:0] exp_fcs;
    } vec_t;

    function automatic vec_t mk(input logic sym, input logic men, input logic min,
                                input logic ctk, input logic cen, input logic cin,
                                input logic exp_mod, input logic [31:0] exp_fcs);
        vec_t v;
        v.sym = sym; v.men = men; v.min = min;
        v.ctk = ctk; v.cen = cen; v.cin = cin;
        v.exp_mod = exp_mod; v.exp_fcs = exp_fcs;
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        int          n;
        logic        saw_eoc;
        logic        cs_stayed;
        logic [31:0] model;
        logic        scr_last;

`ifdef LOCTAG_PHY_SCRAMBLER_EN
        scr_last = 1'b0;
`else
        scr_last = 1'b1;
`endif
        //               sym men min ctk cen cin  mod  fcs
        vecs[0]  = mk(1, 0, 0, 1, 0, 0, 0,        32'h00000000);
        vecs[1]  = mk(1, 1, 1, 1, 1, 1, 1,        32'h04C11DB7);
        vecs[2]  = mk(1, 1, 0, 1, 1, 0, 1,        32'h09823B6E);
        vecs[3]  = mk(0, 1, 1, 0, 0, 1, 1,        32'h09823B6E);
        vecs[4]  = mk(1, 1, 0, 1, 1, 0, 1,        32'h130476DC);
        vecs[5]  = mk(1, 1, 0, 1, 1, 0, 1,        32'h2608EDB8);
        vecs[6]  = mk(1, 1, 0, 0, 1, 1, scr_last, 32'h2608EDB8);
        vecs[7]  = mk(1, 0, 1, 1, 0, 1, 0,        32'h00000000);
        vecs[8]  = mk(1, 1, 0, 1, 1, 0, 0,        32'h00000000);
        vecs[9]  = mk(1, 1, 0, 1, 1, 0, 0,        32'h00000000);
        vecs[10] = mk(1, 1, 0, 1, 1, 0, 0,        32'h00000000);
        vecs[11] = mk(1, 1, 1, 1, 1, 1, 1,        32'h04C11DB7);

        // Reset state
        #5;
        check("rst_cs",   {31'h0, adc_cs},   32'h1);
        check("rst_sclk", {31'h0, adc_sclk}, 32'h1);
        check("rst_eoc",  {31'h0, adc_eoc},  32'h0);
        check("rst_data", {24'h0, adc_data}, 32'h0);
        check("rst_mod",  {31'h0, mod_out},  32'h0);
        check("rst_fcs",  fcs,               32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Basic conversion; a start pulse mid-conversion must be ignored
        tb_frame  = 16'h0A50;
        adc_start = 1'b1;
        tick();
        adc_start = 1'b0;
        check("conv_cs_drop", {31'h0, adc_cs}, 32'h0);
        n = 0;
        while (!adc_eoc && n < 200) begin
            adc_start = (n == 10);
            tick();
            n++;
        end
        adc_start = 1'b0;
        check("conv_cycles", n, 64);
        check("conv_data",   {24'h0, adc_data}, 32'hA5);
        check("conv_cs_hi",  {31'h0, adc_cs},   32'h1);
        check("conv_sclk_hi",{31'h0, adc_sclk}, 32'h1);
        check("conv_rises",  rises, 16);
        tick();
        check("conv_eoc_pulse", {31'h0, adc_eoc}, 32'h0);

        // Modulator / CRC vector table
        for (int i = 0; i < 12; i++) begin
            sym_tick   = vecs[i].sym;
            mod_enable = vecs[i].men;
            mod_in     = vecs[i].min;
            crc_tick   = vecs[i].ctk;
            crc_enable = vecs[i].cen;
            crc_in     = vecs[i].cin;
            tick();
            check($sformatf("vec%0d_mod", i), {31'h0, mod_out}, {31'h0, vecs[i].exp_mod});
            check($sformatf("vec%0d_fcs", i), fcs, vecs[i].exp_fcs);
        end

        // 32 zero CRC ticks against a bitwise reference model
        sym_tick   = 1'b0;
        crc_tick   = 1'b1;
        crc_enable = 1'b1;
        crc_in     = 1'b0;
        model      = 32'h04C11DB7;
        for (int i = 0; i < 32; i++) begin
            model = model[31] ? ((model << 1) ^ 32'h04C11DB7) : (model << 1);
            tick();
            check($sformatf("crc_zero%0d", i), fcs, model);
        end
        crc_tick = 1'b0;
        check("mod_hold", {31'h0, mod_out}, 32'h1);

        // Reset during conversion
        tb_frame  = 16'h0A50;
        adc_start = 1'b1;
        tick();
        adc_start = 1'b0;
        repeat (32) tick();
        check("abort_cs_low", {31'h0, adc_cs}, 32'h0);
        #3;
        reset = 1'b0;
        #1;
        check("abort_cs",   {31'h0, adc_cs},   32'h1);
        check("abort_sclk", {31'h0, adc_sclk}, 32'h1);
        check("abort_eoc",  {31'h0, adc_eoc},  32'h0);
        check("abort_data", {24'h0, adc_data}, 32'h0);
        check("abort_mod",  {31'h0, mod_out},  32'h0);
        check("abort_fcs",  fcs,               32'h0);
        tick();
        tick();
        reset = 1'b1;
        saw_eoc = 1'b0;
        repeat (60) begin
            tick();
            if (adc_eoc) saw_eoc = 1'b1;
        end
        check("abort_no_eoc", {31'h0, saw_eoc}, 32'h0);
        check("abort_data_kept", {24'h0, adc_data}, 32'h0);

        // Next full conversion with modulator and CRC ticks on the eoc cycle
        tb_frame  = 16'h0A50;
        adc_start = 1'b1;
        tick();
        adc_start = 1'b0;
        repeat (63) tick();
        check("sim_no_eoc_yet", {31'h0, adc_eoc}, 32'h0);
        sym_tick   = 1'b1;
        mod_enable = 1'b1;
        mod_in     = 1'b1;
        crc_tick   = 1'b1;
        crc_enable = 1'b1;
        crc_in     = 1'b1;
        tick();
        sym_tick = 1'b0;
        crc_tick = 1'b0;
        check("sim_eoc",  {31'h0, adc_eoc},  32'h1);
        check("sim_data", {24'h0, adc_data}, 32'hA5);
        check("sim_mod",  {31'h0, mod_out},  32'h1);
        check("sim_fcs",  fcs,               32'h04C11DB7);
        check("sim_cs",   {31'h0, adc_cs},   32'h1);

        repeat (8) tick();

        // Held start: back-to-back conversions
        tb_frame  = 16'hF3CF;
        adc_start = 1'b1;
        tick();
        wait_eoc(n);
        check("b2b_first_cycles", n, 64);
        check("b2b_first_data", {24'h0, adc_data}, 32'h3C);
        tick();
        wait_eoc(n);
        check("b2b_gap_cycles", n + 1, 69);
        check("b2b_second_data", {24'h0, adc_data}, 32'h3C);
        adc_start = 1'b0;
        cs_stayed = 1'b1;
        repeat (80) begin
            tick();
            if (!adc_cs) cs_stayed = 1'b0;
        end
        check("b2b_stop", {31'h0, cs_stayed}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
